div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
//  Consumes rs/rt operands from E and writes {hi,lo} to the HI/LO path.
//  Drives div_stallE into the hazard unit's longest_stall term.
//  Holds its result until E actually advances, so other stall sources
//  (instrStall, dataStall, mul_stallE) cannot lose or restart a finished divide.
// PARAMETERS
//  WIDTH    32  operand width; quotient and remainder are WIDTH bits each
//  CNT_W     6  iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1        rising-edge clock
//  resetn       in   1        async active-low reset (single clock domain)
//  start        in   1        DIV/DIVU in E stage, level held while E is stalled
//  signed_div   in   1        1=DIV (two's complement), 0=DIVU; sampled on accept
//  a            in   WIDTH    dividend (rs), sampled on accept
//  b            in   WIDTH    divisor (rt), sampled on accept
//  stall_other  in   1        E held by a non-divider source (instr/data/mul stall)
//  annul        in   1        flush (is_exceptM); aborts any operation
//  result       out  2*WIDTH  {hi=remainder, lo=quotient}
//  ready        out  1        result valid this cycle
//  div_stall    out  1        to hazard unit as div_stallE
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, cnt=0, result=0, ready=0, div_stall=0.
//  States:
//   IDLE: if start & ~annul -> BUSY. Latch |a|,|b|, quotient sign = a[W-1]^b[W-1],
//         remainder sign = a[W-1] (signs forced to 0 when ~signed_div), cnt=0.
//   BUSY: one restoring step per cycle; cnt increments.
//         After WIDTH steps (cnt==WIDTH-1 at the edge) -> DONE with sign-fixed result.
//   DONE: ready=1, result stable. Stays in DONE while stall_other=1.
//         When stall_other=0 (E advances this edge) -> IDLE.
//  div_stall = start & ~(state==DONE) & ~annul; combinational; high in the accept cycle.
//  Latency: accept at edge 0 -> ready high in the cycle after edge WIDTH (33 for WIDTH=32).
//  Exactly one operation per start level: no re-accept while in DONE.
//   A back-to-back divide re-accepts from IDLE on the following cycle.
//  annul=1 in any state -> IDLE next edge; ready=0, result unchanged. annul beats start.
//  start dropping in BUSY (without annul) -> abort to IDLE, same as annul.
//  Divisor zero: no trap. lo = {WIDTH{1'b1}}, hi = a (raw input, no sign fix-up).
//  Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0.
//  Sign fix-up: quotient negated if q_sign; remainder negated if r_sign.
//   Remainder therefore takes the dividend's sign (MIPS rule).
//  Internal arithmetic: remainder path is WIDTH+1 bits so the trial subtract does not overflow.
//  Mid-operation async reset returns to IDLE immediately; no partial result is visible.
// STRUCTURE
//  Shared defines package: WIDTH default, state encodings (IDLE/BUSY/DONE),
//   and the ALU op codes for DIV/DIVU used to form start and signed_div.
//  One sub-module: div_step, a combinational single restoring iteration
//   ({rem,quo} in -> {rem,quo} out). Counter, FSM and sign logic live in div_iter.
// TESTING
//  1. DIVU a=100, b=7, stall_other=0 -> div_stall high 33 cycles; ready pulses 1 cycle; hi=2, lo=14.
//  2. DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  3. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//  4. Hold stall_other=1 for 5 cycles after ready rises -> ready and result stay stable;
//     div_stall=0; no restart. Drop stall_other -> IDLE next edge.
//  5. annul at BUSY cycle 10 -> IDLE next edge, ready never asserts.
//     A fresh start (DIVU 9/3) then gives hi=0, lo=3 after the full latency.
//  6. resetn low at BUSY cycle 20 -> all outputs 0 immediately. Release, reissue DIVU 9/3 -> lo=3.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider and the E-stage decode that drives it.
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    // ALU op codes the decoder uses to raise start/signed_div
    localparam logic [4:0] ALU_DIV  = 5'h0C;
    localparam logic [4:0] ALU_DIVU = 5'h0D;

    function automatic logic isDivOp(input logic [4:0] aluOp);
        return (aluOp == ALU_DIV) || (aluOp == ALU_DIVU);
    endfunction

    function automatic logic isSignedDivOp(input logic [4:0] aluOp);
        return aluOp == ALU_DIV;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH+1:0] remShift;
    logic [WIDTH+1:0] trial;

    always_comb begin
        remShift = {remIn, quoIn[WIDTH-1]};
        trial    = remShift - {2'b00, divisor};
        if (trial[WIDTH+1]) begin
            remOut = remShift[WIDTH:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end else begin
            remOut = trial[WIDTH:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// state | meaning
// IDLE  | waiting for start; operands and signs latched on accept
// BUSY  | one restoring step per cycle, WIDTH steps total
// DONE  | result valid, held until E advances (stall_other low)
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 stall_other,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 div_stall
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    divState_t        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic             qSign;
    logic             rSign;
    logic             divZero;

    logic [WIDTH:0]   stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic [WIDTH-1:0] aAbs;
    logic [WIDTH-1:0] bAbs;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorReg),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // A zero divisor leaves |a| in the remainder; negating it by the dividend
    // sign restores the raw dividend, so only the quotient needs an override.
    always_comb begin
        aAbs   = (signed_div && a[WIDTH-1]) ? -a : a;
        bAbs   = (signed_div && b[WIDTH-1]) ? -b : b;
        quoFix = divZero ? {WIDTH{1'b1}} : (qSign ? -stepQuo : stepQuo);
        remFix = rSign ? -stepRem[WIDTH-1:0] : stepRem[WIDTH-1:0];
    end

    assign div_stall = start & (state != DONE) & ~annul;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            qSign      <= 1'b0;
            rSign      <= 1'b0;
            divZero    <= 1'b0;
            result     <= '0;
            ready      <= 1'b0;
        end else if (annul) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= BUSY;
                        cnt        <= '0;
                        remReg     <= '0;
                        quoReg     <= aAbs;
                        divisorReg <= bAbs;
                        qSign      <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rSign      <= signed_div & a[WIDTH-1];
                        divZero    <= (b == '0);
                    end
                end
                BUSY: begin
                    if (!start) begin
                        state <= IDLE;
                    end else begin
                        remReg <= stepRem;
                        quoReg <= stepQuo;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == LAST_STEP) begin
                            state  <= DONE;
                            ready  <= 1'b1;
                            result <= {remFix, quoFix};
                        end
                    end
                end
                DONE: begin
                    if (!stall_other) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed corner cases plus random operands, checked against
// an arithmetic reference built on 64-bit integer division.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_other;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        div_stall;

    int          errCnt = 0;
    int          chkCnt = 0;
    logic [63:0] lastExp = '0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .signed_div  (signed_div),
        .a           (a),
        .b           (b),
        .stall_other (stall_other),
        .annul       (annul),
        .result      (result),
        .ready       (ready),
        .div_stall   (div_stall)
    );

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {hi=remainder, lo=quotient}; zero divisor gives all-ones quotient and raw dividend
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            sx = $signed(x);
            sy = $signed(y);
        end else begin
            sx = {32'h0, x};
            sy = {32'h0, y};
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Called on a falling edge; returns on a falling edge with start low.
    task automatic runDiv(input logic sgn, input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [63:0] exp;
        int stallCnt;
        int waitCnt;
        exp         = refDiv(sgn, av, bv);
        stallCnt    = 0;
        waitCnt     = 0;
        start       = 1'b1;
        signed_div  = sgn;
        a           = av;
        b           = bv;
        stall_other = (hold > 0);
        #1;
        while (!ready && waitCnt < 100) begin
            if (div_stall) stallCnt++;
            waitCnt++;
            @(negedge clk);
        end
        checkEq("latency", 64'(waitCnt), 64'd33);
        checkEq("stall_cycles", 64'(stallCnt), 64'd33);
        checkEq("result", result, exp);
        checkEq("stall_in_done", 64'(div_stall), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkEq("hold_ready", 64'(ready), 64'd1);
            checkEq("hold_result", result, exp);
            checkEq("hold_stall", 64'(div_stall), 64'd0);
        end
        stall_other = 1'b0;
        start       = 1'b0;
        @(negedge clk);
        checkEq("ready_pulse", 64'(ready), 64'd0);
        checkEq("result_kept", result, exp);
        lastExp = exp;
    endtask

    // Abort an operation with annul or by dropping start, then verify a full fresh divide.
    task automatic abortTest(input logic useAnnul, input int atCycle);
        start       = 1'b1;
        signed_div  = 1'b0;
        a           = 32'hDEAD_BEEF;
        b           = 32'h0000_0013;
        stall_other = 1'b0;
        repeat (atCycle + 1) @(negedge clk);
        if (useAnnul) annul = 1'b1;
        else          start = 1'b0;
        #1;
        checkEq("abort_stall", 64'(div_stall), 64'd0);
        checkEq("abort_ready", 64'(ready), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        checkEq("post_abort_ready", 64'(ready), 64'd0);
        checkEq("post_abort_result", result, lastExp);
        runDiv(1'b0, 32'd9, 32'd3, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sgn;
        logic [31:0] av;
        logic [31:0] bv;
        resetn      = 1'b0;
        start       = 1'b0;
        signed_div  = 1'b0;
        a           = '0;
        b           = '0;
        stall_other = 1'b0;
        annul       = 1'b0;
        #1;
        checkEq("reset_result", result, 64'd0);
        checkEq("reset_ready", 64'(ready), 64'd0);
        checkEq("reset_stall", 64'(div_stall), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        runDiv(1'b0, 32'd100, 32'd7, 0);
        runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        runDiv(1'b0, 32'd5, 32'd0, 0);
        runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        runDiv(1'b1, 32'hFFFF_FFF9, 32'd0, 0);
        runDiv(1'b1, 32'd1234567, 32'hFFFF_FFA7, 5);

        abortTest(1'b1, 10);
        abortTest(1'b0, 5);

        start      = 1'b1;
        signed_div = 1'b0;
        a          = 32'h0ABC_DEF0;
        b          = 32'd77;
        repeat (21) @(negedge clk);
        #2;
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        checkEq("midreset_result", result, 64'd0);
        checkEq("midreset_ready", 64'(ready), 64'd0);
        checkEq("midreset_stall", 64'(div_stall), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        runDiv(1'b0, 32'd9, 32'd3, 0);

        for (int n = 0; n < 24; n++) begin
            sgn = 1'($urandom_range(0, 1));
            av  = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = $urandom;
                1:       bv = $urandom_range(1, 255);
                2:       bv = -($urandom_range(1, 16));
                default: bv = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            runDiv(sgn, av, bv, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
